seg2bin_monitor: RTL and testbench
==================================

Name: seg2bin_monitor

Overview:
- Receive-side counterpart of the hex-to-seven-segment encoder.
- Snoops the multiplexed segment and anode lines driving the display and recovers the hex nibble shown on each digit.
- Sits beside the display driver as a self-check and readback path; the recovered value is comparable against the switch inputs.
- Glitch-filters the scan, flags illegal patterns and detects a stalled scan.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (anode lines).
- STABLE_CYCLES, 4, consecutive identical samples required before a digit commits (>=2).
- TIMEOUT_CYCLES, 1000000, cycles without any commit before the display is declared stale.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- seg7  in  7  segment lines, bit6=a … bit0=g, 1=lit (after optional inversion).
- an  in  NUM_DIGITS  digit select, one-hot, 1=digit enabled (after optional inversion).
- value  out  4*NUM_DIGITS  recovered nibbles; digit i at bits [4i+3:4i].
- digit_valid  out  NUM_DIGITS  per-digit valid flag.
- err  out  1  one-cycle pulse when a non-hex, non-blank pattern commits.
- frame_done  out  1  one-cycle pulse when every digit has committed since the last pulse.
- stale  out  1  scan stalled; no commit for TIMEOUT_CYCLES.

Behaviour:
- Reset values: value=0, digit_valid=0, err=0, frame_done=0, stale=0, stability counter=0, state=SETTLE, frame tracker=0.
- Input stage: {an,seg7} registered once per cycle (sample S). The stage compares S against the previous sample P.
- Stability counter: increments (saturating at STABLE_CYCLES) while S==P; resets to 0 when S!=P.
- FSM SETTLE: commits when the counter reaches STABLE_CYCLES-1 with S==P, then moves to HOLD.
- FSM HOLD: no further commits; returns to SETTLE on any S!=P. Each stable run commits exactly once.
- Commit requires `an` one-hot. All-zero or multi-hot `an` never commits (blanking and overlap); the FSM still tracks stability.
- Decode: the 16 hex patterns are a=…g.
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001
  - 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000
  - 8 = 1111111, 9 = 1111011, A = 1110111, b = 0011111
  - C = 1001110, d = 0111101, E = 1001111, F = 1000111
- Commit outcomes for digit i:
  - Legal pattern: nibble i <= code; digit_valid[i] <= 1.
  - Blank pattern 0000000: digit_valid[i] <= 0; nibble unchanged; no err.
  - Any other pattern: digit_valid[i] <= 0; nibble unchanged; err pulses.
- Latency: outputs update on the clock edge after the commit cycle.
  - From the first cycle a new {an,seg7} is stable at the pins to the outputs updating: STABLE_CYCLES+1 edges.
- Frame tracker: bit i is set on any commit (legal, blank or illegal) to digit i.
  - When all bits are set, frame_done pulses for one cycle and the tracker clears in the same cycle.
  - A commit arriving in that same cycle sets its bit in the freshly cleared tracker.
- Stale detection:
  - The timeout counter resets on every commit and otherwise increments, saturating.
  - On reaching TIMEOUT_CYCLES: stale <= 1, all digit_valid <= 0, tracker cleared; value is held.
  - The next commit clears stale in the same edge as it updates its digit.
- Simultaneous events: commit and timeout in the same cycle means the commit wins (counter resets, stale stays/returns 0).
- Reset mid-scan: all state returns to reset values immediately; the first commit after reset needs a full STABLE_CYCLES run.

Optional Feature:
- Macro: SEG_ACTIVE_LOW_EN.
- Defined: seg7 and an are inverted at the input before registering (common-anode boards, active-low segments and anodes). The blank pattern at the pins is then 1111111.
- Undefined: inputs are used as-is, active-high.

Decomposition:
- Shared package seg7_pkg:
  - SEG_HEX constant array (16 x 7-bit patterns above).
  - SEG_BLANK constant.
  - Segment bit-index constants SEG_A..SEG_G.
  - Used by both encoder and decoder so the tables cannot diverge.
- One combinational sub-module seg7_decode: 7-bit pattern in; nibble, legal and blank out.
- The top-level holds the input register, stability FSM, digit registers, frame tracker and timeout counter.

Test Plan:
- Steady digit: an=0001, seg7=1111001 held 10 cycles -> value[3:0]=3 and digit_valid=0001 on edge STABLE_CYCLES+1; no err.
- Glitch: an=0010, seg7=0110000 for 2 cycles, then 1011011 held 6 cycles -> digit1 commits 5 only; digit1 never takes 1.
- Full frame: scan 4 digits showing A,b,C,d at 8 cycles each -> value=16'hdCbA, digit_valid=1111, one frame_done pulse after digit3 commits.
- Illegal and blank:
  - Digit2 with seg7=0000001 -> err pulses once, digit_valid[2]=0, nibble kept.
  - Digit2 with 0000000 -> digit_valid[2]=0, no err.
  - an=0000 or 0011 stable -> no commit.
- Stall: TIMEOUT_CYCLES=100, stop scan after a full frame -> stale=1 and digit_valid=0 at cycle 100 after the last commit; value held; next commit clears stale.
- Async reset asserted mid-run -> all outputs 0 immediately, without waiting for a clock edge; first commit requires a full stable run.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment tables for hex encoder and decoder
package seg7_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_BLANK   = 7'b0000000;
    localparam logic [6:0] SEG_ALL_LIT = 7'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) |
                                            (1 << SEG_D) | (1 << SEG_E) | (1 << SEG_F) |
                                            (1 << SEG_G));

    // Entry n is the a..g pattern for hex digit n (entry 0 is the rightmost element).
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
        7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
        7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
        7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
    };

    typedef enum logic {
        SETTLE = 1'b0,
        HOLD   = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational seven-segment pattern to hex nibble decoder
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       legal,
    output logic       blank
);

    // Reverse lookup through the shared encoder table.
    always_comb begin
        nibble = 4'd0;
        legal  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_HEX[4'(i)]) begin
                nibble = 4'(i);
                legal  = 1'b1;
            end
        end
    end

    assign blank = ((seg & SEG_ALL_LIT) == SEG_BLANK);

endmodule

// File: rtl/seg2bin_monitor.sv
// rtl/seg2bin_monitor.sv - multiplexed seven-segment readback monitor (option: SEG_ACTIVE_LOW_EN)
module seg2bin_monitor
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg7,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    err,
    output logic                    frame_done,
    output logic                    stale
);

    localparam int SW = NUM_DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_COMMIT = CW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX      = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST     = TW'(TIMEOUT_CYCLES - 1);

    logic [SW-1:0]         pin_word;
    logic [SW-1:0]         samp;
    logic [SW-1:0]         prev;
    logic [CW-1:0]         cnt;
    logic [TW-1:0]         tcnt;
    logic [NUM_DIGITS-1:0] tracker;
    logic [NUM_DIGITS-1:0] s_an;
    logic [NUM_DIGITS-1:0] commit_bits;
    logic [6:0]            s_seg;
    logic [3:0]            nibble;
    logic                  legal;
    logic                  blank;
    logic                  same;
    logic                  settle_done;
    logic                  commit;
    logic                  timeout_hit;
    scan_state_t           state;
    scan_state_t           state_next;

`ifdef SEG_ACTIVE_LOW_EN
    assign pin_word = {~an, seg7 ^ SEG_ALL_LIT};
`else
    assign pin_word = {an, seg7};
`endif

    assign s_an        = samp[SW-1:7];
    assign s_seg       = samp[6:0];
    assign same        = (samp == prev);
    assign commit      = settle_done && $onehot(s_an);
    assign commit_bits = commit ? s_an : '0;
    assign timeout_hit = !commit && (tcnt == T_LAST);
    assign frame_done  = &tracker;

    // Sample the pins, keep the previous sample, and count how long the sample has repeated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp <= '0;
            prev <= '0;
            cnt  <= '0;
        end else begin
            samp <= pin_word;
            prev <= samp;
            if (pin_word != samp) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Stability FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SETTLE;
        end else begin
            state <= state_next;
        end
    end

    // One commit per stable run; any change re-arms the FSM.
    always_comb begin
        state_next  = state;
        settle_done = 1'b0;
        case (state)
            SETTLE: begin
                if (same && (cnt == CNT_COMMIT)) begin
                    settle_done = 1'b1;
                    state_next  = HOLD;
                end
            end
            HOLD: begin
                if (!same) begin
                    state_next = SETTLE;
                end
            end
            default: state_next = SETTLE;
        endcase
    end

    seg7_decode u_decode (
        .seg    (s_seg),
        .nibble (nibble),
        .legal  (legal),
        .blank  (blank)
    );

    // Digit registers, error pulse and stall watchdog; a commit always beats the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value       <= '0;
            digit_valid <= '0;
            err         <= 1'b0;
            stale       <= 1'b0;
            tcnt        <= '0;
        end else begin
            err <= commit && !legal && !blank;
            if (commit) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (s_an[i]) begin
                        if (legal) begin
                            value[4*i +: 4] <= nibble;
                        end
                        digit_valid[i] <= legal;
                    end
                end
                stale <= 1'b0;
                tcnt  <= '0;
            end else if (timeout_hit) begin
                stale       <= 1'b1;
                digit_valid <= '0;
                tcnt        <= T_MAX;
            end else if (tcnt != T_MAX) begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

    // Frame tracker: a full set is visible for one cycle, then restarts with that cycle's commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tracker <= '0;
        end else if (timeout_hit) begin
            tracker <= '0;
        end else if (&tracker) begin
            tracker <= commit_bits;
        end else begin
            tracker <= tracker | commit_bits;
        end
    end

endmodule

// File: tb/tb_seg2bin_monitor.sv
// tb/tb_seg2bin_monitor.sv - self-checking bench for seg2bin_monitor
module tb_seg2bin_monitor;

    localparam int ND = 4;
    localparam int SC = 4;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg7;
    logic [3:0]  an;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic        err;
    logic        frame_done;
    logic        stale;

    always #5 clk = ~clk;

    seg2bin_monitor #(
        .NUM_DIGITS     (ND),
        .STABLE_CYCLES  (SC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg7        (seg7),
        .an          (an),
        .value       (value),
        .digit_valid (digit_valid),
        .err         (err),
        .frame_done  (frame_done),
        .stale       (stale)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt;
    int frame_cnt;

    logic [6:0] hex_tab [16];

    // reference model state
    logic [10:0] m_run;
    int          m_len;
    bit          m_done;
    logic [15:0] m_value;
    logic [3:0]  m_valid;
    logic [3:0]  m_seen;
    bit          m_err;
    bit          m_stale;
    int          m_since;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          cyc;
        logic [15:0] value;
        logic [3:0]  valid;
        int          errs;
        int          frames;
    } vec_t;

    vec_t vt [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (hex_tab[i] == p) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_run   = '0;
        m_len   = 1;
        m_done  = 1'b0;
        m_value = '0;
        m_valid = '0;
        m_seen  = '0;
        m_err   = 1'b0;
        m_stale = 1'b0;
        m_since = 0;
    endtask

    // One clock edge: a run that has been seen SC times in a row is reported once.
    task automatic model_edge(input logic [10:0] pins);
        bit pend;
        bit real_c;
        bit full_before;
        int d;
        int code;
        pend        = (m_len >= SC) && !m_done;
        real_c      = pend && $onehot(m_run[10:7]);
        full_before = (m_seen == 4'hF);
        m_err       = 1'b0;
        if (pend) m_done = 1'b1;
        if (real_c) begin
            d = 0;
            for (int i = 0; i < ND; i++) if (m_run[7+i]) d = i;
            code = lookup(m_run[6:0]);
            if (code >= 0) begin
                m_value[4*d +: 4] = 4'(code);
                m_valid[d] = 1'b1;
            end else begin
                m_valid[d] = 1'b0;
                if (m_run[6:0] != 7'd0) m_err = 1'b1;
            end
            m_stale = 1'b0;
            m_since = 0;
            if (full_before) m_seen = '0;
            m_seen[d] = 1'b1;
        end else begin
            if (full_before) m_seen = '0;
            if (m_since == TO - 1) begin
                m_since = TO;
                m_stale = 1'b1;
                m_valid = '0;
                m_seen  = '0;
            end else if (m_since < TO) begin
                m_since++;
            end
        end
        if (pins == m_run) begin
            if (m_len < 1000) m_len++;
        end else begin
            m_run  = pins;
            m_len  = 1;
            m_done = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge({an, seg7});
        #1;
        if (err) err_cnt++;
        if (frame_done) frame_cnt++;
        check("model_cmp", {9'd0, value, digit_valid, err, frame_done, stale},
              {9'd0, m_value, m_valid, m_err, (m_seen == 4'hF), m_stale});
    endtask

    initial begin
        hex_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

        vt[0]  = '{4'b0010, 7'b0110000, 2, 16'h0003, 4'b0001, 0, 0};
        vt[1]  = '{4'b0010, 7'b1011011, 6, 16'h0053, 4'b0011, 0, 0};
        vt[2]  = '{4'b0001, 7'b1110111, 8, 16'h005A, 4'b0011, 0, 0};
        vt[3]  = '{4'b0010, 7'b0011111, 8, 16'h00BA, 4'b0011, 0, 0};
        vt[4]  = '{4'b0100, 7'b1001110, 8, 16'h0CBA, 4'b0111, 0, 0};
        vt[5]  = '{4'b1000, 7'b0111101, 8, 16'hDCBA, 4'b1111, 0, 1};
        vt[6]  = '{4'b0100, 7'b0000001, 8, 16'hDCBA, 4'b1011, 1, 0};
        vt[7]  = '{4'b0100, 7'b0000000, 8, 16'hDCBA, 4'b1011, 0, 0};
        vt[8]  = '{4'b0000, 7'b1111110, 8, 16'hDCBA, 4'b1011, 0, 0};
        vt[9]  = '{4'b0011, 7'b1111110, 8, 16'hDCBA, 4'b1011, 0, 0};
        vt[10] = '{4'b0100, 7'b1111110, 8, 16'hD0BA, 4'b1111, 0, 0};

        rst_n = 1'b0;
        an    = '0;
        seg7  = '0;
        model_reset();
        err_cnt   = 0;
        frame_cnt = 0;
        tick();
        tick();
        check("reset_value", 32'(value), 32'h0);
        check("reset_valid", 32'(digit_valid), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_frame_done", 32'(frame_done), 32'h0);
        check("reset_stale", 32'(stale), 32'h0);
        rst_n = 1'b1;

        // steady digit: output appears on edge SC+1
        an   = 4'b0001;
        seg7 = 7'b1111001;
        err_cnt = 0;
        repeat (SC) tick();
        check("latency_early_valid", 32'(digit_valid), 32'h0);
        tick();
        check("latency_valid", 32'(digit_valid), 32'h1);
        check("latency_value", 32'(value[3:0]), 32'h3);
        repeat (5) tick();
        check("latency_no_err", 32'(err_cnt), 32'h0);

        for (int v = 0; v < 11; v++) begin
            an        = vt[v].an;
            seg7      = vt[v].seg;
            err_cnt   = 0;
            frame_cnt = 0;
            repeat (vt[v].cyc) tick();
            check($sformatf("vec%0d_value", v), 32'(value), 32'(vt[v].value));
            check($sformatf("vec%0d_valid", v), 32'(digit_valid), 32'(vt[v].valid));
            check($sformatf("vec%0d_errs", v), 32'(err_cnt), 32'(vt[v].errs));
            check($sformatf("vec%0d_frames", v), 32'(frame_cnt), 32'(vt[v].frames));
        end

        // stall: stale exactly TO edges after the last commit edge
        an   = 4'b0001;
        seg7 = 7'b1111110;
        repeat (SC + 1) tick();
        check("stall_commit_value", 32'(value), 32'hD0B0);
        repeat (TO - 1) tick();
        check("stall_not_yet", 32'(stale), 32'h0);
        tick();
        check("stall_stale", 32'(stale), 32'h1);
        check("stall_valid_cleared", 32'(digit_valid), 32'h0);
        check("stall_value_held", 32'(value), 32'hD0B0);
        an   = 4'b0010;
        seg7 = 7'b0110000;
        repeat (SC + 1) tick();
        check("stall_recover_stale", 32'(stale), 32'h0);
        check("stall_recover_valid", 32'(digit_valid), 32'h2);
        check("stall_recover_value", 32'(value), 32'hD010);

        // asynchronous reset mid-run
        an   = 4'b1000;
        seg7 = 7'b1111111;
        repeat (SC + 3) tick();
        check("pre_reset_value", 32'(value), 32'h8010);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_value", 32'(value), 32'h0);
        check("async_reset_valid", 32'(digit_valid), 32'h0);
        check("async_reset_flags", {29'd0, err, frame_done, stale}, 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (SC) tick();
        check("post_reset_early", 32'(digit_valid), 32'h0);
        tick();
        check("post_reset_valid", 32'(digit_valid), 32'h8);
        check("post_reset_value", 32'(value), 32'h8000);

        // randomized scan against the model
        for (int k = 0; k < 300; k++) begin
            int r;
            int hold;
            r = $urandom_range(0, 9);
            if (r < 7) an = 4'(1 << $urandom_range(0, 3));
            else if (r == 7) an = 4'b0000;
            else an = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 9);
            if (r < 8) seg7 = hex_tab[$urandom_range(0, 15)];
            else if (r == 8) seg7 = 7'b0000000;
            else seg7 = 7'($urandom_range(0, 127));
            hold = ($urandom_range(0, 39) == 0) ? 110 : $urandom_range(1, 7);
            repeat (hold) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
